joypad_p1_reg: RTL
==================

# joypad_p1_reg

CPU-side end of the joypad interface: implements the memory-mapped P1/JOYP register at $FF00 that the CPU writes (row select) and reads (button lines). Samples the eight raw, active-low button lines, synchronizes and debounces them, presents the selected row on the read port, and raises the joypad interrupt request on any falling edge of the selected lines. Sits between the board button inputs and the CPU bus / interrupt controller (IF bit 4).

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed before a button change is accepted (≥1).
- `JOYP_ADDR`, 16'hFF00: bus address of the register.
- `Clock` in 1: single system clock.
- `Reset` in 1: reset is synchronous and active-high.
- `iButtons` in 8: raw buttons, 0 = pressed, asynchronous. Bits [7:0] = {Start, Select, B, A, Down, Up, Left, Right}.
- `iAddr` in 16: CPU bus address.
- `iWe` in 1: CPU write strobe, 1 cycle.
- `iRe` in 1: CPU read strobe, 1 cycle.
- `iData` in 8: CPU write data.
- `oData` out 8: registered read data.
- `oIRQ` out 1: joypad interrupt request, level, held until acknowledged.
- `iIRQAck` in 1: interrupt controller acknowledge, clears `oIRQ`.

## Operation
- Synchronizer: 2 flops per button; reset value 8'hFF (released).
- Debounce: per button, states STABLE and CHANGING, with counter width clog2(DEBOUNCE_CYCLES+1).
  - STABLE→CHANGING when the synced value ≠ the debounced value; counter = 1.
  - In CHANGING, counter increments while the mismatch persists.
  - At counter == DEBOUNCE_CYCLES, the debounced value takes the synced value → STABLE, counter = 0.
  - Any match while CHANGING → STABLE, counter = 0, debounced value unchanged.
  - Reset: debounced = 1, STABLE, counter = 0.
- Select register `rSel[1:0]`, reset 2'b11.
  - On `iWe && iAddr==JOYP_ADDR`: `rSel <= iData[5:4]`. `iData[7:6]` and `iData[3:0]` are ignored.
  - Writes to any other address: no effect.
- Nibble (combinational):
  - `rSel[0]==0` selects directions (debounced[3:0]).
  - `rSel[1]==0` selects actions (debounced[7:4]).
  - Both selected: bitwise AND of the two rows.
  - Neither selected: 4'hF.
- Read:
  - On `iRe && iAddr==JOYP_ADDR`: next cycle `oData = {2'b11, rSel, nibble}`.
  - Otherwise `oData = 8'hFF`.
  - Reset 8'hFF.
- IRQ:
  - `rNibblePrev` registers the nibble every cycle; reset 4'hF.
  - Any bit with prev=1 and nibble=0 sets `oIRQ`. This includes drops caused by a `rSel` write.
  - `iIRQAck` clears `oIRQ`. A new edge in the same cycle as ack wins: `oIRQ` stays 1.
  - Rising edges (releases) never set `oIRQ`.
- Simultaneous `iWe` and `iRe` to JOYP_ADDR: the read returns the old `rSel`; the new `rSel` is visible from the next read.
- Reset mid-debounce: counters cleared, pending changes discarded, `oIRQ` = 0.

## Timing
- Read latency: 1 cycle, strobe edge → `oData` valid.
- Write effect: `rSel` updates at the edge sampling `iWe`. The nibble reflects it combinationally after that edge.
- Button edge → synced: 2 cycles. Synced → debounced: DEBOUNCE_CYCLES cycles. Total 2+DEBOUNCE_CYCLES.
- Debounced falling edge on a selected line → `oIRQ` high 1 cycle later (total 3+DEBOUNCE_CYCLES from the input).
- `rSel` write causing a nibble drop → `oIRQ` high 1 cycle after the write edge.
- A synced-level glitch shorter than DEBOUNCE_CYCLES cycles produces no debounced change and no IRQ.
- `oIRQ` clears at the edge sampling `iIRQAck`.

## Structure
- Shared constants in `collaterals.v`: `JOYP_ADDR`, button bit indices, and row-select encodings SEL_DIR=2'b10 and SEL_ACT=2'b01 (values of `rSel`).
- Synchronizer stages use the existing `FFD_POSEDGE_SYNCRONOUS_RESET` (width 8).
- Sub-module `joypad_debounce`: one button (state, counter, debounced bit), parameterized by DEBOUNCE_CYCLES, instantiated 8 times.
- Top level holds `rSel`, the nibble mux, `rNibblePrev`, IRQ logic and the read register.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Reset, then read $FF00 → `oData`=8'hFF; `oIRQ`=0.
- Write 8'h20 (directions), hold Right low (`iButtons`=8'hFE) → debounced after 6 cycles; `oIRQ`=1 at cycle 7; read → 8'hEE.
- Write 8'h10 (actions), press A+Start (8'h6F) → read 8'hD6. Write 8'h00 → read 8'hC6. Write 8'h30 → read 8'hFF.
- Glitch: Up low for 3 synced cycles then released → debounced unchanged, `oIRQ` stays 0, read $FF00 with 8'h20 selected → 8'hEF.
- IRQ/ack collision: with `oIRQ`=1, assert `iIRQAck` in the same cycle a new selected falling edge is detected → `oIRQ` stays 1. Ack alone next cycle → 0.
- Reset mid-debounce (Left low for 2 counted cycles, then Reset) → debounced stays 1, no IRQ. Left held low afterward → debounced 6 cycles after reset release.

Source files
------------

// File: rtl/joypad_p1_reg_pkg.sv
// Shared constants and helpers for the P1/JOYP joypad register.
// Row-select encodings are values of the select register (active-low row enables).
package joypad_p1_reg_pkg;

  localparam logic [15:0] JOYP_ADDR_DFLT = 16'hFF00;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_START = 7;

  localparam logic [1:0] SEL_DIR  = 2'b10;
  localparam logic [1:0] SEL_ACT  = 2'b01;
  localparam logic [1:0] SEL_BOTH = 2'b00;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_CHANGING = 1'b1
  } db_state_e;

  function automatic logic [3:0] row_mux(input logic [1:0] sel,
                                         input logic [3:0] dir_row,
                                         input logic [3:0] act_row);
    logic [3:0] row;
    case (sel)
      SEL_DIR:  row = dir_row;
      SEL_ACT:  row = act_row;
      SEL_BOTH: row = dir_row & act_row;
      default:  row = 4'hF;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/FFD_POSEDGE_SYNCRONOUS_RESET.sv
// Generic enabled D flip-flop bank with synchronous active-high reset.
module FFD_POSEDGE_SYNCRONOUS_RESET #(
  parameter int              SIZE        = 8,
  parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  input  logic [SIZE-1:0] D,
  output logic [SIZE-1:0] Q
);

  // Storage with reset priority over enable
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q <= RESET_VALUE;
    end else if (Enable) begin
      Q <= D;
    end else begin
      Q <= Q;
    end
  end

endmodule

// File: rtl/joypad_debounce.sv
// Single-button debouncer: a change on the synchronized input is accepted
// only after it has persisted for DEBOUNCE_CYCLES consecutive cycles.
module joypad_debounce
  import joypad_p1_reg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iSync,
  output logic oDebounced
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

  db_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            deb_q, deb_d;

  // The count includes the current mismatching cycle, so acceptance happens
  // on the edge that sees the DEBOUNCE_CYCLES-th consecutive mismatch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    cnt_inc = (state_q == DB_CHANGING) ? cnt_q + CW'(1) : CW'(1);
    if (iSync == deb_q) begin
      state_d = DB_STABLE;
      cnt_d   = '0;
    end else if (cnt_inc == CNT_DONE) begin
      deb_d   = iSync;
      state_d = DB_STABLE;
      cnt_d   = '0;
    end else begin
      state_d = DB_CHANGING;
      cnt_d   = cnt_inc;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      deb_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign oDebounced = deb_q;

endmodule

// File: rtl/joypad_p1_reg.sv
// P1/JOYP register: synchronizes and debounces the buttons, muxes the
// selected row onto the CPU read port and raises IRQ on selected falling edges.
module joypad_p1_reg
  import joypad_p1_reg_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] JOYP_ADDR       = JOYP_ADDR_DFLT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  iButtons,
  input  logic [15:0] iAddr,
  input  logic        iWe,
  input  logic        iRe,
  input  logic [7:0]  iData,
  output logic [7:0]  oData,
  output logic        oIRQ,
  input  logic        iIRQAck
);

  logic [7:0] sync1_s, sync2_s, deb_s;
  logic [1:0] sel_q, sel_d;
  logic [3:0] nibble_s, nibble_prev_q;
  logic       irq_q, irq_d, fall_s, wr_hit_s, rd_hit_s;
  logic [7:0] rdata_q, rdata_d;
  logic       data_unused;

  FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(8), .RESET_VALUE(8'hFF)) u_sync1 (
    .Clock(Clock), .Reset(Reset), .Enable(1'b1), .D(iButtons), .Q(sync1_s)
  );

  FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(8), .RESET_VALUE(8'hFF)) u_sync2 (
    .Clock(Clock), .Reset(Reset), .Enable(1'b1), .D(sync1_s), .Q(sync2_s)
  );

  for (genvar i = 0; i < 8; i++) begin : g_deb
    joypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .Clock(Clock), .Reset(Reset), .iSync(sync2_s[i]), .oDebounced(deb_s[i])
    );
  end

  assign data_unused = ^{iData[7:6], iData[3:0]};

  // A new falling edge outranks a same-cycle acknowledge so no press is lost.
  always_comb begin
    wr_hit_s = iWe && (iAddr == JOYP_ADDR);
    rd_hit_s = iRe && (iAddr == JOYP_ADDR);
    sel_d    = wr_hit_s ? iData[5:4] : sel_q;
    nibble_s = row_mux(sel_q, deb_s[BTN_DOWN:BTN_RIGHT], deb_s[BTN_START:BTN_A]);
    fall_s   = |(nibble_prev_q & ~nibble_s);
    if (fall_s) begin
      irq_d = 1'b1;
    end else if (iIRQAck) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
    rdata_d = rd_hit_s ? {2'b11, sel_q, nibble_s} : 8'hFF;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_q         <= 2'b11;
      nibble_prev_q <= 4'hF;
      irq_q         <= 1'b0;
      rdata_q       <= 8'hFF;
    end else begin
      sel_q         <= sel_d;
      nibble_prev_q <= nibble_s;
      irq_q         <= irq_d;
      rdata_q       <= rdata_d;
    end
  end

  assign oData = rdata_q;
  assign oIRQ  = irq_q;

endmodule
